// File: rtl/uart_recv.sv
// 8N1 UART receiver: synchronises din, times the start bit to its midpoint,
// then samples each data bit and the stop bit one bit period apart.
module uart_recv #(
  parameter int BIT_CNT = 10416
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);
  localparam int HALF_CNT = BIT_CNT / 2;
  localparam int CW       = $clog2(BIT_CNT);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF_CNT - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(BIT_CNT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic          sync1, sync2, prev;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shift, shift_n, data_n;
  logic          valid_n, ferr_n;
  logic          line, fall;

  assign line = sync2;
  assign fall = prev & ~sync2;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      prev      <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync1     <= din;
      sync2     <= sync1;
      prev      <= sync2;
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_n;
      shift     <= shift_n;
      data      <= data_n;
      valid     <= valid_n;
      frame_err <= ferr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    shift_n = shift;
    data_n  = data;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (fall) state_n = START;
      end
      START: begin
        if (cnt == HALF_M1) begin
          // a line back high at the start-bit midpoint was only a glitch
          cnt_n   = '0;
          bit_n   = '0;
          state_n = line ? IDLE : DATA;
        end else cnt_n = cnt + 1'b1;
      end
      DATA: begin
        if (cnt == BIT_M1) begin
          cnt_n   = '0;
          shift_n = {line, shift[7:1]};
          bit_n   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = STOP;
        end else cnt_n = cnt + 1'b1;
      end
      STOP: begin
        if (cnt == BIT_M1) begin
          cnt_n   = '0;
          state_n = IDLE;
          if (line) begin
            data_n  = shift;
            valid_n = 1'b1;
          end else ferr_n = 1'b1;
        end else cnt_n = cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule
